// File: rtl/mux_arbiter.sv
// Two-requester burst arbiter driving a shared data path.
// The grant alternates between requesters via a priority pointer, and a burst
// ends on last, on reaching MAX_BURST transfers, or when the owner drops its request.
module mux_arbiter #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             last_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic             last_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_prio;
  logic       w_prio_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_cnt_inc;
  logic       r_sel;
  logic       w_sel;

  // Owner-side view of the current grant, shared by both GRANT states.
  logic       w_own_req;
  logic       w_own_last;
  logic       w_oth_req;
  logic       w_xfer;
  logic       w_release;

  assign w_cnt_inc = r_cnt + 8'd1;

  // Select the owner's request/last and the other requester's request.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_last = 1'b0;
    w_oth_req  = 1'b0;
    unique case (r_state)
      GRANT_A: begin
        w_own_req  = req_a;
        w_own_last = last_a;
        w_oth_req  = req_b;
      end
      GRANT_B: begin
        w_own_req  = req_b;
        w_own_last = last_b;
        w_oth_req  = req_a;
      end
      default: begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_oth_req  = 1'b0;
      end
    endcase
  end

  // A transfer needs a valid beat from the owner and a ready sink; release on
  // a dropped request, a last beat, or the burst limit being reached.
  assign w_xfer    = (r_state != IDLE) && w_own_req && out_ready;
  assign w_release = (r_state != IDLE) &&
                     (!w_own_req ||
                      (w_xfer && (w_own_last || (w_cnt_inc == LP_MAX_BURST))));

  // Next-state, priority and beat-count logic.
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (req_a && (!req_b || !r_prio)) begin
          w_state_nxt = GRANT_A;
        end else if (req_b) begin
          w_state_nxt = GRANT_B;
        end
      end
      GRANT_A: begin
        if (w_release) begin
          w_prio_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = w_oth_req ? GRANT_B : IDLE;
        end else if (w_xfer) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      GRANT_B: begin
        if (w_release) begin
          w_prio_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = w_oth_req ? GRANT_A : IDLE;
        end else if (w_xfer) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode from the state register, so reset clears them at once;
  // sel keeps its previous value while idle.
  always_comb begin
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    w_sel     = r_sel;
    out_valid = 1'b0;
    out_data  = '0;
    unique case (r_state)
      GRANT_A: begin
        gnt_a     = 1'b1;
        w_sel     = 1'b0;
        out_valid = req_a;
        out_data  = data_a;
      end
      GRANT_B: begin
        gnt_b     = 1'b1;
        w_sel     = 1'b1;
        out_valid = req_b;
        out_data  = data_b;
      end
      default: begin
        w_sel = r_sel;
      end
    endcase
  end

  assign sel = w_sel;

  // State, pointer, counter and held-select registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel;
    end
  end

  // Grants are mutually exclusive by construction of the state encoding.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) !(gnt_a && gnt_b));

endmodule
